// File: rtl/fb_read_packet_responder_if.sv
// fb_read_packet_responder_if
//   Groups the command, backpressure and data/status signals of the
//   frame-buffer read responder into one bundle.
//   master : the command source / data sink (divider side, testbench)
//   slave  : the responder itself
//   Command side : i_fval, i_pval, i_aval, section flags, iv_rd_addr,
//                  iv_rd_length in; o_ardy out (from the responder's view)
//   Downstream   : i_drdy in
//   Data/status  : o_fval, o_pval, o_dval, o_last, ov_data, latched flags,
//                  o_cmd_err, ov_pkt_cnt out
interface fb_read_packet_responder_if #(
  parameter int FRAME_BYTE_ADDR_WD = 27,
  parameter int DATA_WD            = 64,
  parameter int PKT_CNT_WD         = 16
);
  logic                          i_fval;
  logic                          i_pval;
  logic                          i_aval;
  logic                          i_info_flag;
  logic                          i_image_flag;
  logic                          i_statis_flag;
  logic [FRAME_BYTE_ADDR_WD-1:0] iv_rd_addr;
  logic [FRAME_BYTE_ADDR_WD-1:0] iv_rd_length;
  logic                          o_ardy;
  logic                          i_drdy;
  logic                          o_fval;
  logic                          o_pval;
  logic                          o_dval;
  logic                          o_last;
  logic [DATA_WD-1:0]            ov_data;
  logic                          o_info_flag;
  logic                          o_image_flag;
  logic                          o_statis_flag;
  logic                          o_cmd_err;
  logic [PKT_CNT_WD-1:0]         ov_pkt_cnt;

  modport master (
    output i_fval, i_pval, i_aval, i_info_flag, i_image_flag, i_statis_flag,
           iv_rd_addr, iv_rd_length, i_drdy,
    input  o_ardy, o_fval, o_pval, o_dval, o_last, ov_data,
           o_info_flag, o_image_flag, o_statis_flag, o_cmd_err, ov_pkt_cnt
  );

  modport slave (
    input  i_fval, i_pval, i_aval, i_info_flag, i_image_flag, i_statis_flag,
           iv_rd_addr, iv_rd_length, i_drdy,
    output o_ardy, o_fval, o_pval, o_dval, o_last, ov_data,
           o_info_flag, o_image_flag, o_statis_flag, o_cmd_err, ov_pkt_cnt
  );
endinterface

// File: rtl/fb_read_packet_responder.sv
// fb_read_packet_responder
//   Read-end responder for the frame-buffer packet divider. Accepts one read
//   command (byte address + byte length) at a time and returns the bytes as
//   DATA_WD-wide beats whose byte k is (addr+k)[7:0], lane 0 in bits [7:0],
//   with the last beat zero-padded. Section flags are latched per command.
//   Ports:
//     clk, reset : single clock, synchronous active-high reset
//     bus        : slave side of fb_read_packet_responder_if
//     dbg_state  : current FSM state (0 = IDLE, 1 = BURST)
//
//   Handshakes: a command transfers on a rising edge where i_aval=1 and the
//   registered o_ardy=1; i_aval may not be withdrawn-and-counted otherwise.
//   A beat transfers on a rising edge in BURST where i_drdy=1; the beat is
//   then visible (o_dval=1) for the following cycle only.
module fb_read_packet_responder #(
  parameter int FRAME_BYTE_ADDR_WD = 27,
  parameter int DATA_WD            = 64,
  parameter int PKT_CNT_WD         = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  fb_read_packet_responder_if.slave   bus,
  output logic                        dbg_state
);
  localparam int BYTE_NUM = DATA_WD / 8;
  localparam int AW       = FRAME_BYTE_ADDR_WD;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           accept, legal, beat_fire, beat_last;
  logic           fval_q, fval_rise;
  logic [7:0]     byte_ptr;   // only the low address byte reaches the data
  logic [AW-1:0]  rem_bytes;  // bytes still to be sent, incl. current beat
  logic [DATA_WD-1:0] beat_data;

  assign dbg_state = state_q;
  assign fval_rise = bus.i_fval & ~fval_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    legal     = 1'b0;
    beat_fire = 1'b0;
    beat_last = (rem_bytes <= AW'(BYTE_NUM));
    case (state_q)
      IDLE: begin
        accept = bus.i_aval & bus.o_ardy;
        legal  = accept & bus.i_fval & (|bus.iv_rd_length);
        if (legal) state_d = BURST;
      end
      BURST: begin
        beat_fire = bus.i_drdy;
        if (beat_fire && beat_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes at or beyond the remaining byte count are zero-padded.
  always_comb begin
    beat_data = '0;
    for (int j = 0; j < BYTE_NUM; j++) begin
      if (rem_bytes > AW'(j)) beat_data[j*8 +: 8] = byte_ptr + 8'(j);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fval_q            <= 1'b0;
      byte_ptr          <= '0;
      rem_bytes         <= '0;
      bus.o_ardy        <= 1'b0;
      bus.o_fval        <= 1'b0;
      bus.o_pval        <= 1'b0;
      bus.o_dval        <= 1'b0;
      bus.o_last        <= 1'b0;
      bus.ov_data       <= '0;
      bus.o_info_flag   <= 1'b0;
      bus.o_image_flag  <= 1'b0;
      bus.o_statis_flag <= 1'b0;
      bus.o_cmd_err     <= 1'b0;
      bus.ov_pkt_cnt    <= '0;
    end else begin
      fval_q        <= bus.i_fval;
      // Stretch frame valid over a burst that outlives i_fval; it drops the
      // cycle after the last beat because state_q is IDLE by then.
      bus.o_fval    <= bus.i_fval | (state_q == BURST);
      bus.o_cmd_err <= accept & ~legal;
      bus.o_dval    <= beat_fire;
      bus.o_last    <= beat_fire & beat_last;
      // o_ardy/o_pval lag the return to IDLE by one cycle so the last beat
      // is seen before the responder advertises readiness again.
      bus.o_ardy    <= (state_q == IDLE) & ~legal;
      if (legal)                bus.o_pval <= 1'b1;
      else if (state_q == IDLE) bus.o_pval <= 1'b0;

      if (beat_fire) begin
        bus.ov_data <= beat_data;
        byte_ptr    <= byte_ptr + 8'(BYTE_NUM);
        rem_bytes   <= rem_bytes - AW'(BYTE_NUM);
      end

      if (legal) begin
        byte_ptr          <= bus.iv_rd_addr[7:0];
        rem_bytes         <= bus.iv_rd_length;
        bus.o_info_flag   <= bus.i_info_flag;
        bus.o_image_flag  <= bus.i_image_flag;
        bus.o_statis_flag <= bus.i_statis_flag;
      end

      // A frame start clears the count; an accept in the same cycle makes it 1.
      if (legal) begin
        if (fval_rise)              bus.ov_pkt_cnt <= PKT_CNT_WD'(1);
        else if (~&bus.ov_pkt_cnt)  bus.ov_pkt_cnt <= bus.ov_pkt_cnt + 1'b1;
      end else if (fval_rise) begin
        bus.ov_pkt_cnt <= '0;
      end
    end
  end
endmodule
